// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the multiplier-sharing controller.
package mul_share_pkg;

    localparam int unsigned MUL_LAT_DEFAULT = 2;
    localparam int unsigned ID_W_MAX        = 2;
    localparam int unsigned TAG_W_MAX       = 16;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_e;

    typedef struct packed {
        logic                 valid;
        logic [ID_W_MAX-1:0]  id;
        logic [TAG_W_MAX-1:0] tag;
        mul_op_e              op;
        logic [31:0]          corr;
    } shadow_t;

    // Correction subtracted from the unsigned high half to get the signed / mixed-sign high half.
    function automatic logic [31:0] hi_corr(input logic [31:0] a, input logic [31:0] b, input mul_op_e op);
        logic        a_sgn;
        logic        b_sgn;
        logic [31:0] ca;
        logic [31:0] cb;
        a_sgn = (op == MULH) || (op == MULHSU);
        b_sgn = (op == MULH);
        ca    = (a_sgn && a[31]) ? b : 32'd0;
        cb    = (b_sgn && b[31]) ? a : 32'd0;
        return ca + cb;
    endfunction

endpackage

// File: rtl/mul_share_rr_arb.sv
// One-hot round-robin arbiter; MUL_SHARE_FIXED_PRIO_EN turns it into lowest-index-wins fixed priority.
module mul_share_rr_arb #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
`ifndef MUL_SHARE_FIXED_PRIO_EN
    input  logic             clk,
    input  logic             rst_n,
`endif
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_any
);

    logic [N_REQ-1:0] pick;

`ifdef MUL_SHARE_FIXED_PRIO_EN
    assign pick = req;
`else
    logic [ID_W-1:0]  ptr_q;
    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] masked;

    // Prefer requesters at or above the pointer, wrap to the rest otherwise.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            mask[ID_W'(i)] = (ID_W'(i) >= ptr_q);
        end
        masked = req & mask;
        pick   = (|masked) ? masked : req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (grant_any) begin
            ptr_q <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end
`endif

    always_comb begin
        grant_id = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pick[ID_W'(i)]) begin
                grant_id = ID_W'(i);
            end
        end
        grant_any = |req;
        grant     = grant_any ? (N_REQ'(1) << grant_id) : '0;
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one pipelined 32x32->64 multiplier between N_REQ requesters with a shadow tracking pipe.
// Build option: MUL_SHARE_FIXED_PRIO_EN selects fixed-priority arbitration instead of round-robin.
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][31:0]      req_a,
    input  logic [N_REQ-1:0][31:0]      req_b,
    input  logic [N_REQ-1:0][1:0]       req_op,
    input  logic [N_REQ-1:0][TAG_W-1:0] req_tag,
    output logic [N_REQ-1:0]            resp_valid,
    output logic [31:0]                 resp_data,
    output logic [TAG_W-1:0]            resp_tag,
    output logic [31:0]                 mul_a,
    output logic [31:0]                 mul_b,
    input  logic [63:0]                 mul_r
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  gid;
    logic             gany;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    mul_op_e          sel_op;
    shadow_t          issue_s;
    shadow_t          pipe_q [MUL_LAT+1];
    shadow_t          fin;

    // No grant is offered while reset is asserted.
    assign arb_req   = req_valid & {N_REQ{rst_n}};
    assign req_ready = grant;

    mul_share_rr_arb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
`ifndef MUL_SHARE_FIXED_PRIO_EN
        .clk       (clk),
        .rst_n     (rst_n),
`endif
        .req       (arb_req),
        .grant     (grant),
        .grant_id  (gid),
        .grant_any (gany)
    );

    always_comb begin
        sel_a         = req_a[gid];
        sel_b         = req_b[gid];
        sel_op        = mul_op_e'(req_op[gid]);
        issue_s       = '0;
        issue_s.valid = gany;
        issue_s.id    = ID_W_MAX'(gid);
        issue_s.tag   = TAG_W_MAX'(req_tag[gid]);
        issue_s.op    = sel_op;
        issue_s.corr  = hi_corr(sel_a, sel_b, sel_op);
    end

    // Operand registers and shadow pipe; the pipe never stalls, matching the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
            for (int i = 0; i <= MUL_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            if (gany) begin
                mul_a <= sel_a;
                mul_b <= sel_b;
            end
            pipe_q[0] <= issue_s;
            for (int i = 1; i <= MUL_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign fin = pipe_q[MUL_LAT];

    // Final stage lines up with mul_r of the same operation.
    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        resp_tag   = '0;
        if (fin.valid) begin
            resp_valid = N_REQ'(1) << fin.id;
            resp_tag   = TAG_W'(fin.tag);
            resp_data  = (fin.op == MUL) ? mul_r[31:0] : (mul_r[63:32] - fin.corr);
        end
    end

endmodule
